// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: op encoding, FSM states,
// byte-lane constants and small op-classification helpers.
package mem_stage_pkg;

    typedef enum logic [2:0] {
        MEM_NONE = 3'd0,
        MEM_LW   = 3'd1,
        MEM_LBU  = 3'd2,
        MEM_SW   = 3'd3,
        MEM_SB   = 3'd4
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } stage_state_e;

    localparam int         LANE_OFS_W = 2;
    localparam logic [1:0] LANE_B0    = 2'd0;
    localparam logic [1:0] LANE_B1    = 2'd1;
    localparam logic [1:0] LANE_B2    = 2'd2;
    localparam logic [1:0] LANE_B3    = 2'd3;

    localparam logic [3:0] MASK_NONE  = 4'h0;
    localparam logic [3:0] MASK_WORD  = 4'hF;
    localparam logic [3:0] MASK_BYTE0 = 4'h1;

    function automatic logic is_store(input mem_op_e op);
        return (op == MEM_SW) || (op == MEM_SB);
    endfunction

    // Word-sized accesses must be word aligned; byte accesses never fault.
    function automatic logic needs_word_align(input mem_op_e op);
        return (op == MEM_LW) || (op == MEM_SW);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store mask/data replication on the request side and
// load byte extraction with zero extension on the response side.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  mem_op_e                st_op,
    input  logic [LANE_OFS_W-1:0]  st_offset,
    input  logic [31:0]            st_data,
    input  mem_op_e                ld_op,
    input  logic [LANE_OFS_W-1:0]  ld_offset,
    input  logic [31:0]            ld_word,
    output logic [3:0]             st_mask,
    output logic [31:0]            st_lane_data,
    output logic [31:0]            ld_data
);

    logic [7:0] ld_byte_s;

    // Store side: full word or a single replicated byte lane.
    always_comb begin
        st_mask      = MASK_NONE;
        st_lane_data = 32'h0000_0000;
        case (st_op)
            MEM_SW: begin
                st_mask      = MASK_WORD;
                st_lane_data = st_data;
            end
            MEM_SB: begin
                st_mask      = MASK_BYTE0 << st_offset;
                st_lane_data = {4{st_data[7:0]}};
            end
            default: begin
                st_mask      = MASK_NONE;
                st_lane_data = 32'h0000_0000;
            end
        endcase
    end

    // Load side: select the addressed byte, then word or zero-extended byte.
    always_comb begin
        ld_byte_s = 8'h00;
        ld_data   = 32'h0000_0000;
        case (ld_offset)
            LANE_B0: ld_byte_s = ld_word[7:0];
            LANE_B1: ld_byte_s = ld_word[15:8];
            LANE_B2: ld_byte_s = ld_word[23:16];
            LANE_B3: ld_byte_s = ld_word[31:24];
            default: ld_byte_s = 8'h00;
        endcase
        case (ld_op)
            MEM_LW:  ld_data = ld_word;
            MEM_LBU: ld_data = {24'h00_0000, ld_byte_s};
            default: ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues data-memory requests on a valid/yumi handshake,
// waits for load data with a bounded timeout, and drives one registered writeback.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int RF_ADDR_W    = 5,
    parameter int RESP_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  mem_op_e              mem_op_i,
    input  logic [31:0]          alu_result_i,
    input  logic [31:0]          store_data_i,
    input  logic                 wb_en_i,
    input  logic [RF_ADDR_W-1:0] wb_addr_i,
    output logic                 dmem_v_o,
    output logic                 dmem_w_o,
    output logic [29:0]          dmem_addr_o,
    output logic [3:0]           dmem_mask_o,
    output logic [31:0]          dmem_data_o,
    input  logic                 dmem_yumi_i,
    input  logic                 dmem_resp_v_i,
    input  logic [31:0]          dmem_resp_data_i,
    output logic                 wb_v_o,
    output logic [RF_ADDR_W-1:0] wb_addr_o,
    output logic [31:0]          wb_data_o,
    output logic                 misalign_o,
    output logic                 timeout_o
);

    // Counter only needs to reach RESP_TIMEOUT-1 before the final waiting cycle.
    localparam int CNT_W = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

    stage_state_e           state_r;
    mem_op_e                op_r;
    logic [LANE_OFS_W-1:0]  ofs_r;
    logic                   wb_en_r;
    logic [RF_ADDR_W-1:0]   wb_addr_r;
    logic [CNT_W-1:0]       cnt_r;

    logic                   accept_s;
    logic                   none_s;
    logic                   misalign_s;
    logic                   start_s;
    logic [3:0]             st_mask_s;
    logic [31:0]            st_lane_data_s;
    logic [31:0]            ld_data_s;

    assign ready_o = (state_r == ST_IDLE);

    mem_lane_align u_lane_align (
        .st_op        (mem_op_i),
        .st_offset    (alu_result_i[1:0]),
        .st_data      (store_data_i),
        .ld_op        (op_r),
        .ld_offset    (ofs_r),
        .ld_word      (dmem_resp_data_i),
        .st_mask      (st_mask_s),
        .st_lane_data (st_lane_data_s),
        .ld_data      (ld_data_s)
    );

    // Classify an instruction accepted in IDLE.
    always_comb begin
        accept_s   = valid_i && (state_r == ST_IDLE);
        none_s     = 1'b0;
        misalign_s = 1'b0;
        start_s    = 1'b0;
        if (accept_s) begin
            case (mem_op_i)
                MEM_NONE: none_s = 1'b1;
                MEM_LW, MEM_SW, MEM_LBU, MEM_SB: begin
                    if (needs_word_align(mem_op_i) && (alu_result_i[1:0] != 2'b00)) begin
                        misalign_s = 1'b1;
                    end else begin
                        start_s = 1'b1;
                    end
                end
                default: none_s = 1'b0;
            endcase
        end else begin
            start_s = 1'b0;
        end
    end

    // Stage FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            op_r        <= MEM_NONE;
            ofs_r       <= 2'b00;
            wb_en_r     <= 1'b0;
            wb_addr_r   <= '0;
            cnt_r       <= '0;
            dmem_v_o    <= 1'b0;
            dmem_w_o    <= 1'b0;
            dmem_addr_o <= 30'h0;
            dmem_mask_o <= 4'h0;
            dmem_data_o <= 32'h0;
            wb_v_o      <= 1'b0;
            wb_addr_o   <= '0;
            wb_data_o   <= 32'h0;
            misalign_o  <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            wb_v_o     <= 1'b0;
            misalign_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (none_s) begin
                        wb_v_o    <= wb_en_i;
                        wb_addr_o <= wb_addr_i;
                        wb_data_o <= alu_result_i;
                    end
                    if (misalign_s) begin
                        misalign_o <= 1'b1;
                    end
                    if (start_s) begin
                        op_r        <= mem_op_i;
                        ofs_r       <= alu_result_i[1:0];
                        wb_en_r     <= wb_en_i;
                        wb_addr_r   <= wb_addr_i;
                        dmem_v_o    <= 1'b1;
                        dmem_w_o    <= is_store(mem_op_i);
                        dmem_addr_o <= alu_result_i[31:2];
                        dmem_mask_o <= st_mask_s;
                        dmem_data_o <= st_lane_data_s;
                        state_r     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dmem_yumi_i) begin
                        dmem_v_o <= 1'b0;
                        dmem_w_o <= 1'b0;
                        cnt_r    <= '0;
                        state_r  <= is_store(op_r) ? ST_IDLE : ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (dmem_resp_v_i) begin
                        wb_v_o    <= wb_en_r;
                        wb_addr_o <= wb_addr_r;
                        wb_data_o <= ld_data_s;
                        state_r   <= ST_IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        timeout_o <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: writebacks are scoreboarded against a queue of
// expected (register, data) pairs; other outputs are checked step by step.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int RF_ADDR_W    = 5;
    localparam int RESP_TIMEOUT = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 valid_i;
    logic                 ready_o;
    mem_op_e              mem_op_i;
    logic [31:0]          alu_result_i;
    logic [31:0]          store_data_i;
    logic                 wb_en_i;
    logic [RF_ADDR_W-1:0] wb_addr_i;
    logic                 dmem_v_o;
    logic                 dmem_w_o;
    logic [29:0]          dmem_addr_o;
    logic [3:0]           dmem_mask_o;
    logic [31:0]          dmem_data_o;
    logic                 dmem_yumi_i;
    logic                 dmem_resp_v_i;
    logic [31:0]          dmem_resp_data_i;
    logic                 wb_v_o;
    logic [RF_ADDR_W-1:0] wb_addr_o;
    logic [31:0]          wb_data_o;
    logic                 misalign_o;
    logic                 timeout_o;

    typedef struct {
        logic [RF_ADDR_W-1:0] addr;
        logic [31:0]          data;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    mem_stage #(.RF_ADDR_W(RF_ADDR_W), .RESP_TIMEOUT(RESP_TIMEOUT)) dut (
        .clk              (clk),
        .reset            (reset),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .mem_op_i         (mem_op_i),
        .alu_result_i     (alu_result_i),
        .store_data_i     (store_data_i),
        .wb_en_i          (wb_en_i),
        .wb_addr_i        (wb_addr_i),
        .dmem_v_o         (dmem_v_o),
        .dmem_w_o         (dmem_w_o),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_mask_o      (dmem_mask_o),
        .dmem_data_o      (dmem_data_o),
        .dmem_yumi_i      (dmem_yumi_i),
        .dmem_resp_v_i    (dmem_resp_v_i),
        .dmem_resp_data_i (dmem_resp_data_i),
        .wb_v_o           (wb_v_o),
        .wb_addr_o        (wb_addr_o),
        .wb_data_o        (wb_data_o),
        .misalign_o       (misalign_o),
        .timeout_o        (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input mem_op_e op, input logic [31:0] alu, input logic [31:0] sd,
                         input logic en, input logic [RF_ADDR_W-1:0] wa);
        valid_i      = 1'b1;
        mem_op_i     = op;
        alu_result_i = alu;
        store_data_i = sd;
        wb_en_i      = en;
        wb_addr_i    = wa;
    endtask

    task automatic push_wb(input logic [RF_ADDR_W-1:0] wa, input logic [31:0] d);
        wb_t e;
        e.addr = wa;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every writeback strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (wb_v_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL wb_unexpected: observed addr %0d data 0x%08h expected no writeback",
                       wb_addr_o, wb_data_o);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_addr", 32'(wb_addr_o), 32'(e.addr));
                chk("wb_data", wb_data_o, e.data);
            end
        end
    end

    initial begin
        reset            = 1'b1;
        valid_i          = 1'b0;
        mem_op_i         = MEM_NONE;
        alu_result_i     = 32'h0;
        store_data_i     = 32'h0;
        wb_en_i          = 1'b0;
        wb_addr_i        = 5'd0;
        dmem_yumi_i      = 1'b0;
        dmem_resp_v_i    = 1'b0;
        dmem_resp_data_i = 32'h0;
        tick();
        tick();
        chk("rst_ready", 32'(ready_o), 32'h1);
        chk("rst_dmem_v", 32'(dmem_v_o), 32'h0);
        chk("rst_dmem_w", 32'(dmem_w_o), 32'h0);
        chk("rst_dmem_addr", 32'(dmem_addr_o), 32'h0);
        chk("rst_wb_v", 32'(wb_v_o), 32'h0);
        chk("rst_timeout", 32'(timeout_o), 32'h0);
        reset = 1'b0;
        tick();

        // MEM_NONE back-to-back, last one without register write
        drive(MEM_NONE, 32'h0000_1234, 32'h0, 1'b1, 5'd3);
        push_wb(5'd3, 32'h0000_1234);
        tick();
        chk("none_ready", 32'(ready_o), 32'h1);
        chk("none_wb_v", 32'(wb_v_o), 32'h1);
        drive(MEM_NONE, 32'h0000_0055, 32'h0, 1'b1, 5'd7);
        push_wb(5'd7, 32'h0000_0055);
        tick();
        chk("none2_wb_data", wb_data_o, 32'h0000_0055);
        drive(MEM_NONE, 32'h0000_0099, 32'h0, 1'b0, 5'd8);
        tick();
        chk("none_noen_wb_v", 32'(wb_v_o), 32'h0);
        valid_i = 1'b0;
        tick();

        // LBU 0x102: yumi after two REQ cycles, stray resp during yumi cycle
        drive(MEM_LBU, 32'h0000_0102, 32'h0, 1'b1, 5'd9);
        push_wb(5'd9, 32'h0000_00BB);
        tick();
        valid_i = 1'b0;
        chk("lbu_dmem_v", 32'(dmem_v_o), 32'h1);
        chk("lbu_dmem_addr", 32'(dmem_addr_o), 32'h40);
        chk("lbu_dmem_w", 32'(dmem_w_o), 32'h0);
        chk("lbu_ready_busy", 32'(ready_o), 32'h0);
        tick();
        chk("lbu_hold_v", 32'(dmem_v_o), 32'h1);
        chk("lbu_hold_addr", 32'(dmem_addr_o), 32'h40);
        dmem_yumi_i      = 1'b1;
        dmem_resp_v_i    = 1'b1;
        dmem_resp_data_i = 32'hFFFF_FFFF;
        tick();
        dmem_yumi_i      = 1'b0;
        dmem_resp_v_i    = 1'b0;
        chk("lbu_after_yumi_v", 32'(dmem_v_o), 32'h0);
        chk("lbu_resp_wait_ready", 32'(ready_o), 32'h0);
        dmem_resp_v_i    = 1'b1;
        dmem_resp_data_i = 32'hAABB_CCDD;
        tick();
        dmem_resp_v_i    = 1'b0;
        chk("lbu_wb_v", 32'(wb_v_o), 32'h1);
        chk("lbu_wb_data", wb_data_o, 32'h0000_00BB);
        chk("lbu_ready_back", 32'(ready_o), 32'h1);
        tick();

        // SB to byte 3: no writeback even with wb_en set
        drive(MEM_SB, 32'h0000_0007, 32'h0000_005A, 1'b1, 5'd4);
        tick();
        valid_i = 1'b0;
        chk("sb_dmem_v", 32'(dmem_v_o), 32'h1);
        chk("sb_dmem_w", 32'(dmem_w_o), 32'h1);
        chk("sb_mask", 32'(dmem_mask_o), 32'h8);
        chk("sb_data", dmem_data_o, 32'h5A5A_5A5A);
        chk("sb_addr", 32'(dmem_addr_o), 32'h1);
        dmem_yumi_i = 1'b1;
        tick();
        dmem_yumi_i = 1'b0;
        chk("sb_done_ready", 32'(ready_o), 32'h1);
        chk("sb_done_v", 32'(dmem_v_o), 32'h0);

        // SW aligned, immediate yumi
        drive(MEM_SW, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 5'd0);
        tick();
        valid_i = 1'b0;
        chk("sw_mask", 32'(dmem_mask_o), 32'hF);
        chk("sw_data", dmem_data_o, 32'hDEAD_BEEF);
        chk("sw_addr", 32'(dmem_addr_o), 32'h4);
        dmem_yumi_i = 1'b1;
        tick();
        dmem_yumi_i = 1'b0;
        chk("sw_done_ready", 32'(ready_o), 32'h1);

        // Misaligned SW: pulse only, no request
        drive(MEM_SW, 32'h0000_0006, 32'h1111_2222, 1'b1, 5'd2);
        tick();
        valid_i = 1'b0;
        chk("mis_pulse", 32'(misalign_o), 32'h1);
        chk("mis_no_req", 32'(dmem_v_o), 32'h0);
        chk("mis_ready", 32'(ready_o), 32'h1);
        tick();
        chk("mis_pulse_end", 32'(misalign_o), 32'h0);

        // LW with no response: times out after RESP_TIMEOUT cycles in RESP
        drive(MEM_LW, 32'h0000_0020, 32'h0, 1'b1, 5'd5);
        tick();
        valid_i     = 1'b0;
        dmem_yumi_i = 1'b1;
        tick();
        dmem_yumi_i = 1'b0;
        for (int i = 0; i < RESP_TIMEOUT - 1; i++) tick();
        chk("to_not_yet", 32'(timeout_o), 32'h0);
        chk("to_busy", 32'(ready_o), 32'h0);
        tick();
        chk("to_set", 32'(timeout_o), 32'h1);
        chk("to_ready", 32'(ready_o), 32'h1);
        dmem_resp_v_i    = 1'b1;
        dmem_resp_data_i = 32'h1234_5678;
        tick();
        dmem_resp_v_i    = 1'b0;
        tick();
        chk("to_sticky", 32'(timeout_o), 32'h1);
        chk("to_stray_ready", 32'(ready_o), 32'h1);

        // Reset while a request is outstanding, then a clean LW
        drive(MEM_LW, 32'h0000_0040, 32'h0, 1'b1, 5'd6);
        tick();
        valid_i = 1'b0;
        chk("rr_req_v", 32'(dmem_v_o), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rr_dmem_v", 32'(dmem_v_o), 32'h0);
        chk("rr_dmem_addr", 32'(dmem_addr_o), 32'h0);
        chk("rr_dmem_mask", 32'(dmem_mask_o), 32'h0);
        chk("rr_timeout", 32'(timeout_o), 32'h0);
        chk("rr_ready", 32'(ready_o), 32'h1);
        drive(MEM_LW, 32'h0000_0044, 32'h0, 1'b1, 5'd6);
        push_wb(5'd6, 32'hCAFE_F00D);
        tick();
        valid_i = 1'b0;
        chk("rr_lw_addr", 32'(dmem_addr_o), 32'h11);
        dmem_yumi_i = 1'b1;
        tick();
        dmem_yumi_i      = 1'b0;
        dmem_resp_v_i    = 1'b1;
        dmem_resp_data_i = 32'hCAFE_F00D;
        tick();
        dmem_resp_v_i = 1'b0;
        chk("rr_lw_wb_v", 32'(wb_v_o), 32'h1);
        tick();
        tick();
        chk("sb_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
